// File: rtl/mc_alu_if.sv
// mc_alu_if: request/response bundle between the controller and mc_alu.
// master drives the operation; slave returns results and status.
interface mc_alu_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [3:0]       alucontrol;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             busy;
  logic             done;
  logic             divbyzero;
  logic             illegal;

  modport master (
    output start,
    output alucontrol,
    output a,
    output b,
    input  result,
    input  hi,
    input  zero,
    input  busy,
    input  done,
    input  divbyzero,
    input  illegal
  );

  modport slave (
    input  start,
    input  alucontrol,
    input  a,
    input  b,
    output result,
    output hi,
    output zero,
    output busy,
    output done,
    output divbyzero,
    output illegal
  );
endinterface

// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU; shift-add MUL, restoring DIV, 1-cycle logic/shift.
// Define MC_ALU_EARLY_EXIT_EN to end MUL once the multiplier runs out of ones.
module mc_alu #(
  parameter int WIDTH = 32
) (
  input logic   clk,
  input logic   reset_n,
  mc_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d, cnt_n;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;
  logic             ill_q, ill_d;

  logic             busy_o, done_o;
  logic             op_is_mul;

  logic [WIDTH-1:0] sc_res, sc_hi;
  logic             sc_dbz, sc_ill, sc_long;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_n, mul_lo_n;
  logic [2*WIDTH-1:0] mul_full;
  logic               mul_last;

  logic [WIDTH:0]   div_trial, div_sub;
  logic             div_ok;
  logic [WIDTH-1:0] div_hi_n, div_lo_n;

`ifdef MC_ALU_EARLY_EXIT_EN
  logic [WIDTH-1:0] mrem_q, mrem_d;
`endif

  assign op_is_mul = (bus.alucontrol == OP_MUL);
  assign cnt_n     = cnt_q - CW'(1);

  // Single-cycle results, plus whether the op needs the iterative path
  always_comb begin
    sc_res  = '0;
    sc_hi   = '0;
    sc_dbz  = 1'b0;
    sc_ill  = 1'b0;
    sc_long = 1'b0;
    unique case (bus.alucontrol)
      OP_AND: sc_res = bus.a & bus.b;
      OP_OR:  sc_res = bus.a | bus.b;
      OP_ADD: sc_res = bus.a + bus.b;
      OP_SUB: sc_res = bus.a - bus.b;
      OP_MUL: begin
`ifdef MC_ALU_EARLY_EXIT_EN
        sc_long = (bus.b != '0);
`else
        sc_long = 1'b1;
`endif
      end
      OP_DIV: begin
        if (bus.b == '0) begin
          sc_res = '1;
          sc_hi  = bus.a;
          sc_dbz = 1'b1;
        end else begin
          sc_long = 1'b1;
        end
      end
      OP_SLL: sc_res = bus.a << bus.b[SHW-1:0];
      OP_SRL: sc_res = bus.a >> bus.b[SHW-1:0];
      OP_NOT: sc_res = ~bus.a;
      default: sc_ill = 1'b1;
    endcase
  end

  // Shift-add step: {acc_hi, acc_lo} shifts right, multiplier in acc_lo
  always_comb begin
    mul_sum  = {1'b0, acc_hi_q}
             + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
`ifdef MC_ALU_EARLY_EXIT_EN
    // Unconsumed multiplier bits are zero, so the product sits cnt_n bits high
    mul_full = {mul_hi_n, mul_lo_n} >> cnt_n;
    mul_last = (cnt_q == CW'(1)) || ((mrem_q >> 1) == '0);
`else
    mul_full = {mul_hi_n, mul_lo_n};
    mul_last = (cnt_q == CW'(1));
`endif
  end

  // Restoring step: remainder in acc_hi, dividend/quotient in acc_lo
  always_comb begin
    div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_sub   = div_trial - {1'b0, opb_q};
    div_ok    = ~div_sub[WIDTH];
    div_hi_n  = div_ok ? div_sub[WIDTH-1:0]
                       : div_trial[WIDTH-1:0];
    div_lo_n  = {acc_lo_q[WIDTH-2:0], div_ok};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (!sc_long) begin
            state_d = S_DONE;
          end else if (op_is_mul) begin
            state_d = S_MUL;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_MUL: if (mul_last) state_d = S_DONE;
      S_DIV: if (cnt_q == CW'(1)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    unique case (state_q)
      S_MUL, S_DIV: busy_o = 1'b1;
      S_DONE:       done_o = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    dbz_d    = dbz_q;
    ill_d    = ill_q;
`ifdef MC_ALU_EARLY_EXIT_EN
    mrem_d   = mrem_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dbz_d = sc_dbz;
          ill_d = sc_ill;
          if (sc_long) begin
            cnt_d    = CW'(WIDTH);
            acc_hi_d = '0;
            acc_lo_d = op_is_mul ? bus.b : bus.a;
            opb_d    = op_is_mul ? bus.a : bus.b;
`ifdef MC_ALU_EARLY_EXIT_EN
            mrem_d   = bus.b;
`endif
          end else begin
            result_d = sc_res;
            hi_d     = sc_hi;
            zero_d   = (sc_res == '0);
          end
        end
      end
      S_MUL: begin
        cnt_d    = cnt_n;
        acc_hi_d = mul_hi_n;
        acc_lo_d = mul_lo_n;
`ifdef MC_ALU_EARLY_EXIT_EN
        mrem_d   = mrem_q >> 1;
`endif
        if (mul_last) begin
          result_d = mul_full[WIDTH-1:0];
          hi_d     = mul_full[2*WIDTH-1:WIDTH];
          zero_d   = (mul_full[WIDTH-1:0] == '0);
        end
      end
      S_DIV: begin
        cnt_d    = cnt_n;
        acc_hi_d = div_hi_n;
        acc_lo_d = div_lo_n;
        if (cnt_q == CW'(1)) begin
          result_d = div_lo_n;
          hi_d     = div_hi_n;
          zero_d   = (div_lo_n == '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
`ifdef MC_ALU_EARLY_EXIT_EN
      mrem_q   <= '0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      dbz_q    <= dbz_d;
      ill_q    <= ill_d;
`ifdef MC_ALU_EARLY_EXIT_EN
      mrem_q   <= mrem_d;
`endif
    end
  end

  assign bus.result    = result_q;
  assign bus.hi        = hi_q;
  assign bus.zero      = zero_q;
  assign bus.divbyzero = dbz_q;
  assign bus.illegal   = ill_q;
  assign bus.busy      = busy_o;
  assign bus.done      = done_o;

endmodule

// File: tb/tb_mc_alu.sv
// tb_mc_alu: directed vectors for mc_alu with hand-computed results.
// Latency counts clock edges from the start edge to the first done sample.
module tb_mc_alu;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1000;
  localparam logic [3:0] OP_BAD = 4'b1010;

`ifdef MC_ALU_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  mc_alu_if #(.WIDTH(32)) bus ();

  mc_alu #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag,
                     input logic [3:0] op,
                     input logic [31:0] ia,
                     input logic [31:0] ib,
                     input int lat_e,
                     input logic [31:0] res_e,
                     input logic [31:0] hi_e,
                     input logic z_e,
                     input logic dbz_e,
                     input logic ill_e,
                     input bit glitch);
    int lat;
    int nbusy;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.alucontrol = op;
    bus.a          = ia;
    bus.b          = ib;
    lat   = 0;
    nbusy = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        bus.start      = 1'b0;
        bus.alucontrol = OP_SUB;
        bus.a          = ~ia;
        bus.b          = ~ib;
      end
      if (glitch && lat == 5) begin
        bus.start      = 1'b1;
        bus.alucontrol = OP_AND;
      end
      if (glitch && lat == 6) bus.start = 1'b0;
      if (bus.busy) nbusy++;
    end while (!bus.done && lat < 100);
    bus.start = 1'b0;
    chk({tag, ".lat"}, 64'(lat), 64'(lat_e));
    chk({tag, ".res"}, 64'(bus.result), 64'(res_e));
    chk({tag, ".hi"}, 64'(bus.hi), 64'(hi_e));
    chk({tag, ".zero"}, 64'(bus.zero), 64'(z_e));
    chk({tag, ".dbz"}, 64'(bus.divbyzero), 64'(dbz_e));
    chk({tag, ".ill"}, 64'(bus.illegal), 64'(ill_e));
    chk({tag, ".busycyc"}, 64'(nbusy), 64'(lat_e - 1));
    @(posedge clk);
    #1;
    chk({tag, ".pulse"}, 64'(bus.done), 64'(0));
    chk({tag, ".hold"}, 64'(bus.result), 64'(res_e));
  endtask

  initial begin
    int nd;
    errors         = 0;
    checks         = 0;
    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.alucontrol = '0;
    bus.a          = '0;
    bus.b          = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.res", 64'(bus.result), 64'(0));
    chk("rst.hi", 64'(bus.hi), 64'(0));
    chk("rst.zero", 64'(bus.zero), 64'(0));
    chk("rst.busy", 64'(bus.busy), 64'(0));
    chk("rst.done", 64'(bus.done), 64'(0));
    chk("rst.dbz", 64'(bus.divbyzero), 64'(0));
    chk("rst.ill", 64'(bus.illegal), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    run("addwrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 1,
        32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    run("subwrap", OP_SUB, 32'h0, 32'h1, 1,
        32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort a MUL with an asynchronous reset at cycle 5
    @(negedge clk);
    bus.start      = 1'b1;
    bus.alucontrol = OP_MUL;
    bus.a          = 32'd7;
    bus.b          = 32'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst.busy", 64'(bus.busy), 64'(0));
    chk("midrst.done", 64'(bus.done), 64'(0));
    chk("midrst.res", 64'(bus.result), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) nd++;
    end
    chk("midrst.nodone", 64'(nd), 64'(0));
    run("add34", OP_ADD, 32'd3, 32'd4, 1,
        32'd7, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    run("mulhi", OP_MUL, 32'h8000_0000, 32'd4, EE ? 4 : 33,
        32'h0, 32'h2, 1'b1, 1'b0, 1'b0, 1'b0);
    run("mulmax", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33,
        32'h1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    run("mul32", OP_MUL, 32'd3, 32'd2, EE ? 3 : 33,
        32'd6, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    run("mulb1", OP_MUL, 32'd12345, 32'd1, EE ? 2 : 33,
        32'd12345, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    run("mulb0", OP_MUL, 32'd5, 32'd0, EE ? 1 : 33,
        32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    run("div100", OP_DIV, 32'd100, 32'd7, 33,
        32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    run("divbig", OP_DIV, 32'hFFFF_FFFF, 32'h10, 33,
        32'h0FFF_FFFF, 32'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    run("div0", OP_DIV, 32'd5, 32'd0, 1,
        32'hFFFF_FFFF, 32'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    run("and", OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 1,
        32'h0000_F000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    run("or", OP_OR, 32'h1200_0034, 32'h0056_7800, 1,
        32'h1256_7834, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    run("sll", OP_SLL, 32'd1, 32'h25, 1,
        32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    run("srl", OP_SRL, 32'h8000_0000, 32'd31, 1,
        32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    run("not", OP_NOT, 32'h0, 32'h0, 1,
        32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    run("illegal", OP_BAD, 32'h1234, 32'h5678, 1,
        32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    run("busystart", OP_DIV, 32'd100, 32'd7, 33,
        32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
